// File: rtl/mult_issue_hilo_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_issue_hilo_if
//  Description : Bus between the HI/LO issue stage and the sequential
//                shift-add multiplier.
//                  mult_run          - one-cycle run strobe to the multiplier
//                  mult_multiplicand - operand magnitude (from rs)
//                  mult_multiplier   - operand magnitude (from rt)
//                  mult_ready        - multiplier ready level
//                  mult_product      - unsigned 2*WIDTH product
//                master = issue stage, slave = multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_issue_hilo_if #(
  parameter int WIDTH = 32
);
  logic                 mult_run;
  logic [WIDTH-1:0]     mult_multiplicand;
  logic [WIDTH-1:0]     mult_multiplier;
  logic                 mult_ready;
  logic [2*WIDTH-1:0]   mult_product;

  modport master (
    output mult_run,
    output mult_multiplicand,
    output mult_multiplier,
    input  mult_ready,
    input  mult_product
  );

  modport slave (
    input  mult_run,
    input  mult_multiplicand,
    input  mult_multiplier,
    output mult_ready,
    output mult_product
  );
endinterface
`default_nettype wire

// File: rtl/mult_issue_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : mult_issue_hilo
//  Description : Issue and result stage for the sequential multiplier.
//                Takes MULT/MULTU requests, hands operand magnitudes to the
//                multiplier, waits for its ready edge, sign-corrects the
//                product and writes HI/LO. Also serves MTHI/MTLO writes.
//  Ports       : clk, reset      - clock, async active-high reset
//                start           - multiply request (accepted in IDLE only)
//                is_signed       - 1 = MULT, 0 = MULTU
//                op_a, op_b      - rs / rt operands
//                mthi_we/mtlo_we - write wdata to HI/LO (IDLE only)
//                wdata           - MTHI/MTLO data
//                hi, lo          - architectural HI/LO registers
//                busy            - high whenever not IDLE (pipeline stall)
//                done            - one-cycle pulse in the HI/LO write cycle
//                mult            - multiplier bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_issue_hilo #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic             is_signed,
  input  wire logic [WIDTH-1:0] op_a,
  input  wire logic [WIDTH-1:0] op_b,
  input  wire logic             mthi_we,
  input  wire logic             mtlo_we,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] hi,
  output logic      [WIDTH-1:0] lo,
  output logic                  busy,
  output logic                  done,
  mult_issue_hilo_if.master     mult
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               neg;
  logic               ready_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               ready_rise;
  logic [2*WIDTH-1:0] product_fixed;

  // Magnitude as an unsigned WIDTH-bit value; the most negative number
  // negates onto itself, which is exactly its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] x);
    mag = (sgn && x[WIDTH-1]) ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  assign mag_a = mag(is_signed, op_a);
  assign mag_b = mag(is_signed, op_b);

  // Only a low-to-high transition counts, so a ready level left over from a
  // previous operation can never complete a new one.
  assign ready_rise = mult.mult_ready && !ready_q;

  assign product_fixed = neg ? (~mult.mult_product + {{(2*WIDTH-1){1'b0}}, 1'b1})
                             : mult.mult_product;

  // Outputs decoded straight from the state register.
  assign busy                   = (state != ST_IDLE);
  assign done                   = (state == ST_WRITE);
  assign mult.mult_run          = (state == ST_ISSUE);
  assign mult.mult_multiplicand = multiplicand;
  assign mult.mult_multiplier   = multiplier;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      hi           <= '0;
      lo           <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
      neg          <= 1'b0;
      ready_q      <= 1'b0;
      product_q    <= '0;
    end else begin
      ready_q <= mult.mult_ready;
      case (state)
        ST_IDLE: begin
          if (mthi_we) hi <= wdata;
          if (mtlo_we) lo <= wdata;
          if (start) begin
            multiplicand <= mag_a;
            multiplier   <= mag_b;
            neg          <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_rise) begin
            product_q <= product_fixed;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          hi    <= product_q[2*WIDTH-1:WIDTH];
          lo    <= product_q[WIDTH-1:0];
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mult_issue_hilo.md
Name: mult_issue_hilo

Overview:
Front-end and result stage for the sequential 32x32 shift-add multiplier.
- Accepts MULT/MULTU requests from the CPU datapath.
- Converts signed operands to magnitudes and holds them stable on the multiplier inputs.
- Pulses the multiplier's run, waits for its ready, sign-corrects the 64-bit product, and writes it to the architectural HI/LO registers.
- Serves MFHI/MFLO reads, handles MTHI/MTLO writes, and raises busy so the pipeline can stall.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH each, product is 2*WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request a multiply; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU
op_a  input  WIDTH  rs operand
op_b  input  WIDTH  rt operand
mthi_we  input  1  write wdata to HI (IDLE only)
mtlo_we  input  1  write wdata to LO (IDLE only)
wdata  input  WIDTH  MTHI/MTLO data
hi  output  WIDTH  HI register (MFHI source)
lo  output  WIDTH  LO register (MFLO source)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse in the cycle HI/LO are written
mult_run  output  1  run strobe to multiplier
mult_multiplicand  output  WIDTH  registered magnitude of op_a
mult_multiplier  output  WIDTH  registered magnitude of op_b
mult_ready  input  1  multiplier ready
mult_product  input  2*WIDTH  multiplier unsigned product

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - hi=lo=0, mult_multiplicand=mult_multiplier=0.
  - mult_run=0, done=0, busy=0.
  - Internal neg flag and ready_q are cleared.
- FSM states: IDLE, ISSUE, WAIT, WRITE.
- IDLE:
  - If start=1 on an edge:
    - Latch mag(op_a) and mag(op_b) into mult_multiplicand/mult_multiplier.
    - neg <= is_signed & (op_a[MSB]^op_b[MSB]).
    - Go to ISSUE.
  - mag(x) = (is_signed & x[MSB]) ? -x : x, taken as WIDTH-bit unsigned; 0x80000000 maps to 0x80000000 (valid unsigned 2^31).
- ISSUE:
  - mult_run=1 for exactly this one cycle; next state is WAIT.
  - Operand registers hold their values until the next accepted start.
- WAIT:
  - ready_q is mult_ready registered every cycle.
  - Completion is a rising edge only: mult_ready=1 and ready_q=0.
  - A ready level that is high at entry is not accepted until it has been seen low.
  - On completion, capture p = neg ? (~mult_product + 1) mod 2^(2*WIDTH) : mult_product, then go to WRITE.
  - No timeout; the block waits indefinitely.
- WRITE:
  - hi <= p[2W-1:W], lo <= p[W-1:0], done=1 for this cycle; next state is IDLE.
  - hi/lo show the new value from the following cycle.
- Latency: start edge to done = 3 + multiplier latency; a new start is accepted the cycle after done.
- start while busy: ignored; no queuing, no latch.
- mthi_we/mtlo_we:
  - In IDLE, hi/lo <= wdata on the edge; both may assert in the same cycle.
  - While busy they are ignored; the pipeline must stall on busy.
- start together with mthi/mtlo in IDLE: both take effect; the multiply result overwrites HI/LO at WRITE.
- Reset mid-operation:
  - Immediate return to IDLE; hi/lo zeroed; mult_run deasserted in the same cycle.
  - The multiplier's late ready after reset is ignored, because only WAIT observes it.
- busy is combinational from state; done and mult_run are decoded from state (glitch-free, single cycle).

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, multiplier model latency 33 -> mult operands 0xFFFFFFFF/0xFFFFFFFF, one-cycle mult_run, done after 36 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 7 -> mult operands 3/7, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> operands 0x80000000/0x80000000, hi=0x40000000, lo=0.
- MULT 5 x -5 with mult_ready held high before and through ISSUE, then low 4 cycles, then high -> completion only on the later rising edge; hi=0xFFFFFFFF, lo=0xFFFFFFE7.
- start re-asserted in every WAIT cycle during a 6x7 MULTU -> exactly one mult_run pulse and one done; lo=42, hi=0.
- mthi_we wdata=0x1234 while busy is ignored (hi unchanged after done=0); in IDLE mthi_we+mtlo_we wdata=0xABCD -> hi=lo=0xABCD next cycle.
- reset asserted mid-WAIT -> same-cycle busy=0, hi=lo=0, mult_run=0; a subsequent ready pulse produces no done; the next start completes normally.
